frame_randomizer: RTL and testbench
===================================

# frame_randomizer

Parametrised, frame-aware bit-stream randomizer. It XORs a streaming data path with the keystream of a Fibonacci LFSR, processing `DATA_W` bits per clock under valid/ready handshakes. A pending seed register and an automatic reseed at every frame boundary let each frame start from a known state. It sits between the framing block and the FEC/modulator and replaces the fixed 15-bit serial randomizer in new datapaths.

## Interface
- `LFSR_W`, 15, LFSR state width.
- `TAPS`, 15'h0003, feedback mask; feedback = XOR-reduce(state & TAPS).
- `DATA_W`, 8, bits processed per accepted beat (1..32).
- `DEF_SEED`, 15'h3715, seed after reset; must be non-zero.
- `CNT_W`, 16, frame-counter width.
- `Clock` in 1 — rising-edge clock.
- `Reset` in 1 — synchronous, active-high; dominates every other input.
- `Enable` in 1 — global clock enable; when low, all state and outputs hold.
- `bypass` in 1 — when high, the keystream is forced to 0 (data passes unchanged), but the LFSR still advances.
- `seed_load` in 1 — one-cycle strobe that captures `seed` into the pending seed register.
- `seed` in LFSR_W — new seed value.
- `seed_err` out 1 — one-cycle pulse when `seed_load` carries an all-zero seed.
- `s_valid`, `s_ready`, `s_data[DATA_W]`, `s_last` — input stream.
- `m_valid`, `m_ready`, `m_data[DATA_W]`, `m_last` — output stream.
- `frame_cnt` out CNT_W — number of completed frames.

## Operation
- Per-bit rule, applied LSB first within a beat, for i = 0..DATA_W-1:
  - k = ^(state & TAPS)
  - m_data[i] = s_data[i] ^ (bypass ? 0 : k)
  - state = {k, state[LFSR_W-1:1]}
- All DATA_W steps complete combinationally within one accepted beat.
- Registers: `state`, `seed_reg`, FSM, output register, `frame_cnt`.
- Reset values:
  - state = DEF_SEED, seed_reg = DEF_SEED
  - FSM = SOF
  - m_valid = 0, m_data = 0, m_last = 0
  - seed_err = 0, frame_cnt = 0
- FSM:
  - SOF: waiting for the first beat of a frame. On accept, go to BODY, or stay in SOF if `s_last` is set (single-beat frame).
  - BODY: on accept with `s_last`, go to SOF. At the same edge, state is loaded with seed_reg instead of the advanced value, and frame_cnt increments.
- frame_cnt wraps modulo 2^CNT_W.
- Seed handling:
  - A `seed_load` with non-zero `seed` updates seed_reg only. It takes effect at the next frame boundary and never mid-frame.
  - Exception: if the FSM is in SOF, no beat is accepted that cycle, and `seed_load` fires, state is also loaded from `seed` immediately.
  - An all-zero `seed` is rejected: seed_reg is unchanged and seed_err pulses.
- `seed_load` on the same cycle as an accepted `s_last`: the new seed wins and is loaded into both seed_reg and state.
- `bypass` is sampled per beat and may change mid-frame.
- Reset mid-frame drops the in-flight output beat and forces SOF with the default seed. A previously loaded seed is lost.
- Enable low: s_ready is driven 0 and m_valid holds. Transfers occur only on cycles with Enable high.

## Timing
- Accept condition: s_valid && s_ready && Enable.
- Emit condition: m_valid && m_ready && Enable.
- s_ready = Enable && (!m_valid || m_ready). This is a combinational path from m_ready. It gives full throughput of one beat per clock.
- Latency: 1 cycle from the accepting edge to m_valid/m_data/m_last registered.
- Under backpressure (m_valid && !m_ready), m_data, m_last and m_valid hold stable and the LFSR does not advance.
- seed_err is registered and asserts the cycle after the `seed_load` edge.
- frame_cnt is registered and updates on the edge that accepts `s_last`.

## Structure
- Package `randomizer_pkg`:
  - default constants LFSR_W, TAPS, DEF_SEED
  - FSM state typedef {SOF, BODY}
  - function `lfsr_step(state, taps)`, returning the next state and the key bit
- Sub-module `lfsr_keygen`: a combinational DATA_W-step unroll producing keystream[DATA_W] and next_state. The top level holds the FSM, handshake, seed and counter logic.

## Test plan
- Reset, then a 2-beat frame s_data = 0x00, 0x00 with `s_last` on beat 2 (defaults) -> m_data = 0x9F then 0x6C, m_last on beat 2, frame_cnt = 1. The next frame's first beat is again 0x9F.
- `bypass` = 1, s_data = 0xA5 -> m_data = 0xA5, and the LFSR still advances: the next beat with bypass = 0 and s_data 0x00 yields 0x6C.
- `seed_load` with seed 0x3715 mid-frame after a prior load of 0x0001 -> the current frame continues unchanged, and the next frame starts with 0x9F.
- `seed_load` with seed 0x0000 -> seed_err pulses 1 cycle, seed_reg stays 0x3715, and output is unchanged.
- Hold m_ready = 0 for 5 cycles with s_valid = 1 -> s_ready = 0, m_data stable, and no beats lost or duplicated after release. A random-backpressure run matches the reference model.
- Assert Reset in BODY with m_valid = 1 -> next cycle m_valid = 0, frame_cnt = 0, and the next input beat 0x00 yields 0x9F.

Source files
------------

// File: rtl/frame_randomizer_pkg.sv
// Shared constants, FSM encoding and the single-step LFSR helper for the
// frame randomizer datapath.
package randomizer_pkg;

    localparam int LFSR_MAX = 32;

    localparam int          RND_LFSR_W   = 15;
    localparam logic [14:0] RND_TAPS     = 15'h0003;
    localparam logic [14:0] RND_DEF_SEED = 15'h3715;
    localparam int          RND_DATA_W   = 8;
    localparam int          RND_CNT_W    = 16;

    typedef enum logic [0:0] {
        SOF  = 1'b0,
        BODY = 1'b1
    } fsm_t;

    typedef struct packed {
        logic [LFSR_MAX-1:0] next_state;
        logic                key;
    } lfsr_step_t;

    // One Fibonacci shift: state is zero-extended to LFSR_MAX, msb_mask marks
    // the real top bit where the feedback re-enters.
    function automatic lfsr_step_t lfsr_step(
        input logic [LFSR_MAX-1:0] state,
        input logic [LFSR_MAX-1:0] taps,
        input logic [LFSR_MAX-1:0] msb_mask
    );
        lfsr_step_t r;
        r.key        = ^(state & taps);
        r.next_state = (state >> 1) | (r.key ? msb_mask : {LFSR_MAX{1'b0}});
        return r;
    endfunction

endpackage

// File: rtl/frame_randomizer_if.sv
// Valid/ready stream bundle carrying one data beat plus an end-of-frame flag.
interface frame_randomizer_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/frame_randomizer_keygen.sv
// Combinational DATA_W-step LFSR unroll: bit i of the keystream is the key
// produced by the i-th shift, LSB first.
module lfsr_keygen
    import randomizer_pkg::*;
#(
    parameter int                LFSR_W = RND_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(RND_TAPS),
    parameter int                DATA_W = RND_DATA_W
)(
    input  logic [LFSR_W-1:0] state_i,
    output logic [DATA_W-1:0] keystream_o,
    output logic [LFSR_W-1:0] next_state_o
);

    localparam logic [LFSR_MAX-1:0] TAPS_EXT = LFSR_MAX'(TAPS);
    localparam logic [LFSR_MAX-1:0] MSB_MASK =
        {{(LFSR_MAX-1){1'b0}}, 1'b1} << (LFSR_W - 1);

    logic [LFSR_MAX-1:0] cur_s;
    logic [DATA_W-1:0]   key_s;
    lfsr_step_t          step_s;

    // Chain DATA_W single steps within one cycle.
    always_comb begin
        cur_s               = {LFSR_MAX{1'b0}};
        cur_s[LFSR_W-1:0]   = state_i;
        key_s               = {DATA_W{1'b0}};
        step_s              = '0;
        for (int i = 0; i < DATA_W; i++) begin
            step_s   = lfsr_step(cur_s, TAPS_EXT, MSB_MASK);
            key_s[i] = step_s.key;
            cur_s    = step_s.next_state;
        end
    end

    assign keystream_o  = key_s;
    assign next_state_o = cur_s[LFSR_W-1:0];

endmodule

// File: rtl/frame_randomizer.sv
// Frame-aware stream randomizer: XORs each accepted beat with an LFSR
// keystream and reseeds the LFSR at every frame boundary.
module frame_randomizer
    import randomizer_pkg::*;
#(
    parameter int                LFSR_W   = RND_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(RND_TAPS),
    parameter int                DATA_W   = RND_DATA_W,
    parameter logic [LFSR_W-1:0] DEF_SEED = LFSR_W'(RND_DEF_SEED),
    parameter int                CNT_W    = RND_CNT_W
)(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Enable,
    input  logic                bypass,
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed,
    output logic                seed_err,
    frame_randomizer_if.slave   s_if,
    frame_randomizer_if.master  m_if,
    output logic [CNT_W-1:0]    frame_cnt
);

    fsm_t              fsm_q, fsm_d;
    logic [LFSR_W-1:0] state_q, state_d;
    logic [LFSR_W-1:0] seed_reg_q, seed_reg_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;
    logic              seed_err_q, seed_err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic              s_ready_s;
    logic              accept_s;
    logic              seed_zero_s;
    logic              seed_ok_s;
    logic [DATA_W-1:0] keystream_s;
    logic [DATA_W-1:0] key_used_s;
    logic [LFSR_W-1:0] adv_state_s;

    lfsr_keygen #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .DATA_W (DATA_W)
    ) u_keygen (
        .state_i      (state_q),
        .keystream_o  (keystream_s),
        .next_state_o (adv_state_s)
    );

    // Handshake qualifiers; s_ready is combinational from m_ready for full rate.
    always_comb begin
        s_ready_s   = Enable && (!m_valid_q || m_if.ready);
        accept_s    = s_if.valid && s_ready_s;
        seed_zero_s = (seed == {LFSR_W{1'b0}});
        seed_ok_s   = Enable && seed_load && !seed_zero_s;
        key_used_s  = bypass ? {DATA_W{1'b0}} : keystream_s;
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fsm_q <= SOF;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next-state: any accepted last beat closes the frame.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            SOF: begin
                if (accept_s && !s_if.last) begin
                    fsm_d = BODY;
                end else begin
                    fsm_d = SOF;
                end
            end
            BODY: begin
                if (accept_s && s_if.last) begin
                    fsm_d = SOF;
                end else begin
                    fsm_d = BODY;
                end
            end
            default: fsm_d = SOF;
        endcase
    end

    // FSM outputs: LFSR/seed/counter/output-register updates.
    always_comb begin
        state_d     = state_q;
        seed_reg_d  = seed_reg_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        seed_err_d  = seed_err_q;
        frame_cnt_d = frame_cnt_q;
        if (Enable) begin
            seed_err_d = seed_load && seed_zero_s;
            if (seed_ok_s) begin
                seed_reg_d = seed;
            end else begin
                seed_reg_d = seed_reg_q;
            end
            if (accept_s) begin
                m_valid_d = 1'b1;
                m_data_d  = s_if.data ^ key_used_s;
                m_last_d  = s_if.last;
                if (s_if.last) begin
                    // A seed arriving with the closing beat wins over the pending one.
                    state_d     = seed_ok_s ? seed : seed_reg_q;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1'b1);
                end else begin
                    state_d = adv_state_s;
                end
            end else begin
                if (m_if.ready) begin
                    m_valid_d = 1'b0;
                end else begin
                    m_valid_d = m_valid_q;
                end
                if ((fsm_q == SOF) && seed_ok_s) begin
                    state_d = seed;
                end else begin
                    state_d = state_q;
                end
            end
        end else begin
            state_d = state_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= DEF_SEED;
            seed_reg_q  <= DEF_SEED;
            m_valid_q   <= 1'b0;
            m_data_q    <= {DATA_W{1'b0}};
            m_last_q    <= 1'b0;
            seed_err_q  <= 1'b0;
            frame_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            seed_reg_q  <= seed_reg_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            seed_err_q  <= seed_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_if.ready = s_ready_s;
    assign m_if.valid = m_valid_q;
    assign m_if.data  = m_data_q;
    assign m_if.last  = m_last_q;
    assign seed_err   = seed_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_randomizer.sv
// Directed vector table plus hand-written backpressure/reset sequences and a
// random-backpressure run against a bit-serial reference model.
module tb_frame_randomizer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        bypass;
    logic        seed_load;
    logic [14:0] seed;
    logic        seed_err;
    logic [15:0] frame_cnt;

    frame_randomizer_if #(.DATA_W(8)) s_if ();
    frame_randomizer_if #(.DATA_W(8)) m_if ();

    frame_randomizer #(
        .LFSR_W   (15),
        .TAPS     (15'h0003),
        .DATA_W   (8),
        .DEF_SEED (15'h3715),
        .CNT_W    (16)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Enable    (Enable),
        .bypass    (bypass),
        .seed_load (seed_load),
        .seed      (seed),
        .seed_err  (seed_err),
        .s_if      (s_if),
        .m_if      (m_if),
        .frame_cnt (frame_cnt)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        byp;
        logic        v;
        logic [7:0]  d;
        logic        last;
        logic        sl;
        logic [14:0] sd;
        logic        e_mv;
        logic [7:0]  e_md;
        logic        e_ml;
        logic [15:0] e_fc;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic byp, input logic v, input logic [7:0] d,
                                input logic last, input logic sl, input logic [14:0] sd,
                                input logic e_mv, input logic [7:0] e_md, input logic e_ml,
                                input logic [15:0] e_fc, input logic e_err);
        vec_t r;
        r.byp = byp; r.v = v; r.d = d; r.last = last; r.sl = sl; r.sd = sd;
        r.e_mv = e_mv; r.e_md = e_md; r.e_ml = e_ml; r.e_fc = e_fc; r.e_err = e_err;
        return r;
    endfunction

    // Reference: one beat processed bit-serially; returns {next_state, data}.
    function automatic logic [22:0] model_beat(input logic [14:0] st, input logic [7:0] din,
                                               input logic byp);
        logic [14:0] s;
        logic [7:0]  o;
        logic        k;
        s = st;
        o = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k    = s[0] ^ s[1];
            o[i] = din[i] ^ (byp ? 1'b0 : k);
            s    = {k, s[14:1]};
        end
        return {s, o};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    vec_t        vecs[20];
    logic [8:0]  expq[$];
    logic [14:0] mstate;
    logic [22:0] mres;
    logic [8:0]  popped;
    logic        exp_mv;
    logic        acc;

    // Random-backpressure / drain cycle body shared by both phases.
    task automatic rand_cycle(input logic sv, input logic mr, input logic [7:0] sd,
                              input logic sl, input logic byp);
        s_if.valid = sv; s_if.data = sd; s_if.last = sl; bypass = byp; m_if.ready = mr;
        #1;
        chk("rnd_s_ready", 32'(s_if.ready), 32'(!exp_mv || mr));
        chk("rnd_m_valid", 32'(m_if.valid), 32'(exp_mv));
        if (exp_mv && mr) begin
            if (expq.size() == 0) begin
                chk("rnd_q_nonempty", 32'(0), 32'(1));
            end else begin
                popped = expq.pop_front();
                chk("rnd_m_data", 32'(m_if.data), 32'(popped[7:0]));
                chk("rnd_m_last", 32'(m_if.last), 32'(popped[8]));
            end
        end
        acc = sv && (!exp_mv || mr);
        if (acc) begin
            mres = model_beat(mstate, sd, byp);
            expq.push_back({sl, mres[7:0]});
            mstate = sl ? 15'h3715 : mres[22:8];
        end
        exp_mv = acc ? 1'b1 : (exp_mv && !mr);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Enable = 1'b1; bypass = 1'b0; seed_load = 1'b0; seed = 15'h0000;
        s_if.valid = 1'b0; s_if.data = 8'h00; s_if.last = 1'b0; m_if.ready = 1'b1;
        tick(); tick();
        chk("rst_m_valid",   32'(m_if.valid), 32'(0));
        chk("rst_m_data",    32'(m_if.data),  32'(0));
        chk("rst_m_last",    32'(m_if.last),  32'(0));
        chk("rst_frame_cnt", 32'(frame_cnt),  32'(0));
        chk("rst_seed_err",  32'(seed_err),   32'(0));
        chk("rst_s_ready",   32'(s_if.ready), 32'(1));
        Reset = 1'b0;

        //            byp  v    d      last sl   seed     mv   md     ml   fc      err
        vecs[0]  = mk(1'b0,1'b1,8'h00,1'b0,1'b0,15'h0000,1'b1,8'h9F,1'b0,16'd0, 1'b0);
        vecs[1]  = mk(1'b0,1'b1,8'h00,1'b1,1'b0,15'h0000,1'b1,8'h6C,1'b1,16'd1, 1'b0);
        vecs[2]  = mk(1'b0,1'b1,8'hFF,1'b0,1'b0,15'h0000,1'b1,8'h60,1'b0,16'd1, 1'b0);
        vecs[3]  = mk(1'b0,1'b1,8'h00,1'b1,1'b0,15'h0000,1'b1,8'h6C,1'b1,16'd2, 1'b0);
        vecs[4]  = mk(1'b1,1'b1,8'hA5,1'b0,1'b0,15'h0000,1'b1,8'hA5,1'b0,16'd2, 1'b0);
        vecs[5]  = mk(1'b0,1'b1,8'h00,1'b1,1'b0,15'h0000,1'b1,8'h6C,1'b1,16'd3, 1'b0);
        vecs[6]  = mk(1'b0,1'b0,8'h00,1'b0,1'b1,15'h0001,1'b0,8'h6C,1'b1,16'd3, 1'b0);
        vecs[7]  = mk(1'b0,1'b1,8'h00,1'b0,1'b0,15'h0000,1'b1,8'h01,1'b0,16'd3, 1'b0);
        vecs[8]  = mk(1'b0,1'b0,8'h00,1'b0,1'b1,15'h3715,1'b0,8'h01,1'b0,16'd3, 1'b0);
        vecs[9]  = mk(1'b0,1'b1,8'h00,1'b1,1'b0,15'h0000,1'b1,8'hC0,1'b1,16'd4, 1'b0);
        vecs[10] = mk(1'b0,1'b1,8'h0F,1'b0,1'b0,15'h0000,1'b1,8'h90,1'b0,16'd4, 1'b0);
        vecs[11] = mk(1'b0,1'b0,8'h00,1'b0,1'b1,15'h0000,1'b0,8'h90,1'b0,16'd4, 1'b1);
        vecs[12] = mk(1'b0,1'b1,8'h00,1'b1,1'b0,15'h0000,1'b1,8'h6C,1'b1,16'd5, 1'b0);
        vecs[13] = mk(1'b0,1'b1,8'h00,1'b1,1'b0,15'h0000,1'b1,8'h9F,1'b1,16'd6, 1'b0);
        vecs[14] = mk(1'b0,1'b1,8'h00,1'b1,1'b0,15'h0000,1'b1,8'h9F,1'b1,16'd7, 1'b0);
        vecs[15] = mk(1'b0,1'b1,8'h00,1'b0,1'b0,15'h0000,1'b1,8'h9F,1'b0,16'd7, 1'b0);
        vecs[16] = mk(1'b0,1'b1,8'h00,1'b1,1'b1,15'h0001,1'b1,8'h6C,1'b1,16'd8, 1'b0);
        vecs[17] = mk(1'b0,1'b1,8'h00,1'b0,1'b0,15'h0000,1'b1,8'h01,1'b0,16'd8, 1'b0);
        vecs[18] = mk(1'b0,1'b1,8'h00,1'b1,1'b0,15'h0000,1'b1,8'hC0,1'b1,16'd9, 1'b0);
        vecs[19] = mk(1'b0,1'b1,8'h00,1'b1,1'b0,15'h0000,1'b1,8'h01,1'b1,16'd10,1'b0);

        for (int i = 0; i < 20; i++) begin
            bypass = vecs[i].byp; s_if.valid = vecs[i].v; s_if.data = vecs[i].d;
            s_if.last = vecs[i].last; seed_load = vecs[i].sl; seed = vecs[i].sd;
            tick();
            chk($sformatf("vec%0d_m_valid", i),   32'(m_if.valid), 32'(vecs[i].e_mv));
            chk($sformatf("vec%0d_m_data", i),    32'(m_if.data),  32'(vecs[i].e_md));
            chk($sformatf("vec%0d_m_last", i),    32'(m_if.last),  32'(vecs[i].e_ml));
            chk($sformatf("vec%0d_frame_cnt", i), 32'(frame_cnt),  32'(vecs[i].e_fc));
            chk($sformatf("vec%0d_seed_err", i),  32'(seed_err),   32'(vecs[i].e_err));
        end
        seed_load = 1'b0; bypass = 1'b0;

        // Reset while in BODY with an output beat pending; loaded seed is lost.
        s_if.valid = 1'b1; s_if.data = 8'h00; s_if.last = 1'b0; m_if.ready = 1'b0;
        tick();
        chk("pre_rst_m_valid", 32'(m_if.valid), 32'(1));
        chk("pre_rst_m_data",  32'(m_if.data),  32'(8'h01));
        Reset = 1'b1; s_if.valid = 1'b0;
        tick();
        chk("midrst_m_valid",   32'(m_if.valid), 32'(0));
        chk("midrst_frame_cnt", 32'(frame_cnt),  32'(0));
        Reset = 1'b0; s_if.valid = 1'b1; m_if.ready = 1'b1;
        tick();
        chk("postrst_m_data",  32'(m_if.data),  32'(8'h9F));
        chk("postrst_m_valid", 32'(m_if.valid), 32'(1));

        // Backpressure: output holds, no acceptance, Enable low freezes everything.
        m_if.ready = 1'b0; s_if.valid = 1'b1; s_if.data = 8'h00;
        #1;
        chk("bp_s_ready", 32'(s_if.ready), 32'(0));
        for (int c = 0; c < 5; c++) begin
            @(posedge Clock); #2;
            chk($sformatf("bp%0d_m_valid", c), 32'(m_if.valid), 32'(1));
            chk($sformatf("bp%0d_m_data", c),  32'(m_if.data),  32'(8'h9F));
            chk($sformatf("bp%0d_s_ready", c), 32'(s_if.ready), 32'(0));
        end
        Enable = 1'b0; m_if.ready = 1'b1;
        #1;
        chk("en_low_s_ready", 32'(s_if.ready), 32'(0));
        @(posedge Clock); #2;
        chk("en_low_m_valid", 32'(m_if.valid), 32'(1));
        chk("en_low_m_data",  32'(m_if.data),  32'(8'h9F));
        Enable = 1'b1;
        #1;
        chk("release_s_ready", 32'(s_if.ready), 32'(1));
        @(posedge Clock); #1;
        chk("release_m_data",  32'(m_if.data),  32'(8'h6C));
        chk("release_m_valid", 32'(m_if.valid), 32'(1));
        s_if.valid = 1'b0;
        tick();
        chk("drain_m_valid", 32'(m_if.valid), 32'(0));

        // Random backpressure against the reference model, starting from reset.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        mstate = 15'h3715;
        exp_mv = 1'b0;
        for (int c = 0; c < 300; c++) begin
            rand_cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                       8'($urandom_range(0, 255)),
                       ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                       ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
        end
        for (int c = 0; c < 4; c++) begin
            rand_cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        chk("rnd_queue_empty", 32'(expq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
